// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared direction and mode encodings for the up/down modulo-N counter
package counter_pkg;

  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;
  typedef enum logic {MODE_WRAP = 1'b0, MODE_SAT = 1'b1} mode_e;

endpackage

// File: rtl/counter_step.sv
// rtl/counter_step.sv - combinational next-count, wrap/saturate events and terminal-count decode
module counter_step
  import counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] limit,
  input  dir_e             dir,
  input  mode_e            mode,
  output logic [WIDTH-1:0] next_count,
  output logic             wrap_evt,
  output logic             sat_evt,
  output logic             tc
);

  always_comb begin
    next_count = count;
    wrap_evt   = 1'b0;
    sat_evt    = 1'b0;
    if (dir == DIR_UP) begin
      if (count < limit) begin
        next_count = count + 1'b1;
      end else if (mode == MODE_WRAP) begin
        next_count = '0;
        wrap_evt   = 1'b1;
      end else begin
        next_count = limit;
        sat_evt    = 1'b1;
      end
    end else begin
      // A count above limit only happens after limit was lowered; snap back without wrapping.
      if (count > limit) begin
        next_count = limit;
      end else if (count != '0) begin
        next_count = count - 1'b1;
      end else if (mode == MODE_WRAP) begin
        next_count = limit;
        wrap_evt   = 1'b1;
      end else begin
        next_count = '0;
        sat_evt    = 1'b1;
      end
    end
  end

  assign tc = (dir == DIR_UP) ? (count >= limit) : (count == '0);

endmodule

// File: rtl/counter_updown_mod_n.sv
// rtl/counter_updown_mod_n.sv - programmable up/down modulo-N counter and frequency divider
module counter_updown_mod_n
  import counter_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             div_out,
  output logic             sat_hit
);

  localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] next_count;
  logic             wrap_evt;
  logic             sat_evt;

  counter_step #(.WIDTH(WIDTH)) u_step (
    .count      (count),
    .limit      (limit),
    .dir        (dir_e'(up_dn)),
    .mode       (mode_e'(sat)),
    .next_count (next_count),
    .wrap_evt   (wrap_evt),
    .sat_evt    (sat_evt),
    .tc         (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= RST_COUNT;
      wrap    <= 1'b0;
      div_out <= 1'b0;
      sat_hit <= 1'b0;
    end else if (load) begin
      count   <= (load_val > limit) ? limit : load_val;
      wrap    <= 1'b0;
      sat_hit <= 1'b0;
    end else if (en) begin
      count <= next_count;
      wrap  <= wrap_evt;
      if (wrap_evt) div_out <= ~div_out;
      if (sat_evt) sat_hit <= 1'b1;
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_counter_updown_mod_n.sv
// tb/tb_counter_updown_mod_n.sv - directed self-checking bench for counter_updown_mod_n
module tb_counter_updown_mod_n;

  logic       clk = 1'b0;
  logic       rst, en, up_dn, sat, load;
  logic [3:0] load_val, limit;
  logic [3:0] count;
  logic       tc, wrap, div_out, sat_hit;

  int checks = 0;
  int errors = 0;

  counter_updown_mod_n #(.WIDTH(4), .RESET_VALUE(0)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_dn    (up_dn),
    .sat      (sat),
    .load     (load),
    .load_val (load_val),
    .limit    (limit),
    .count    (count),
    .tc       (tc),
    .wrap     (wrap),
    .div_out  (div_out),
    .sat_hit  (sat_hit)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] c, input logic w,
                         input logic d, input logic s);
    chk({tag, ".count"}, {4'h0, count}, {4'h0, c});
    chk({tag, ".wrap"}, {7'h0, wrap}, {7'h0, w});
    chk({tag, ".div_out"}, {7'h0, div_out}, {7'h0, d});
    chk({tag, ".sat_hit"}, {7'h0, sat_hit}, {7'h0, s});
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up_dn = 1'b1; sat = 1'b0; load = 1'b0;
    load_val = 4'd0; limit = 4'd9;

    // 1: reset, then count up 0..9 wrapping, divider period 20
    step(); step();
    chk_all("reset", 4'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; en = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk_all($sformatf("up_wrap[%0d]", i), 4'(i % 10), (i % 10) == 0,
              (i >= 10) && (i < 20), 1'b0);
      chk($sformatf("up_tc[%0d]", i), {7'h0, tc}, {7'h0, (i % 10) == 9});
    end

    // 2: down wrap from 2 with limit 5
    en = 1'b0; load = 1'b1; load_val = 4'd2; limit = 4'd5; up_dn = 1'b0;
    step();
    chk_all("dn_load", 4'd2, 1'b0, 1'b0, 1'b0);
    load = 1'b0; en = 1'b1;
    step(); chk_all("dn1", 4'd1, 1'b0, 1'b0, 1'b0);
    step(); chk_all("dn0", 4'd0, 1'b0, 1'b0, 1'b0);
    chk("dn_tc0", {7'h0, tc}, 8'h1);
    step(); chk_all("dn5", 4'd5, 1'b1, 1'b1, 1'b0);
    chk("dn_tc5", {7'h0, tc}, 8'h0);
    step(); chk_all("dn4", 4'd4, 1'b0, 1'b1, 1'b0);

    // 3: saturate up at limit 3, sticky sat_hit cleared by load
    en = 1'b0; load = 1'b1; load_val = 4'd0; limit = 4'd3; up_dn = 1'b1; sat = 1'b1;
    step(); load = 1'b0; en = 1'b1;
    step(); chk_all("sat1", 4'd1, 1'b0, 1'b1, 1'b0);
    step(); chk_all("sat2", 4'd2, 1'b0, 1'b1, 1'b0);
    step(); chk_all("sat3", 4'd3, 1'b0, 1'b1, 1'b0);
    chk("sat_tc", {7'h0, tc}, 8'h1);
    step(); chk_all("sat3b", 4'd3, 1'b0, 1'b1, 1'b1);
    step(); chk_all("sat3c", 4'd3, 1'b0, 1'b1, 1'b1);
    en = 1'b0; load = 1'b1; load_val = 4'd1;
    step(); chk_all("sat_clr", 4'd1, 1'b0, 1'b1, 1'b0);

    // 4: load clamp and load-over-enable priority
    limit = 4'd9; load_val = 4'd12; sat = 1'b0;
    step(); chk_all("clamp", 4'd9, 1'b0, 1'b1, 1'b0);
    en = 1'b1; load_val = 4'd4;
    step(); chk_all("ld_prio", 4'd4, 1'b0, 1'b1, 1'b0);

    // 5: limit lowered below count (up wrap, up saturate, down)
    en = 1'b0; load_val = 4'd8;
    step(); load = 1'b0; limit = 4'd5; en = 1'b1;
    step(); chk_all("lim_up_wrap", 4'd0, 1'b1, 1'b0, 1'b0);
    en = 1'b0; load = 1'b1; limit = 4'd9;
    step(); load = 1'b0; limit = 4'd5; sat = 1'b1; en = 1'b1;
    step(); chk_all("lim_up_sat", 4'd5, 1'b0, 1'b0, 1'b1);
    en = 1'b0; load = 1'b1; limit = 4'd9;
    step(); load = 1'b0; limit = 4'd5; sat = 1'b0; up_dn = 1'b0; en = 1'b1;
    step(); chk_all("lim_dn", 4'd5, 1'b0, 1'b0, 1'b0);

    // 6: limit 0 wrap toggles div_out, build count 7 with sat_hit, then reset over load+en
    en = 1'b0; load = 1'b1; load_val = 4'd0; limit = 4'd0; up_dn = 1'b1;
    step(); load = 1'b0; en = 1'b1;
    step(); chk_all("lim0_a", 4'd0, 1'b1, 1'b1, 1'b0);
    step(); chk_all("lim0_b", 4'd0, 1'b1, 1'b0, 1'b0);
    step(); chk_all("lim0_c", 4'd0, 1'b1, 1'b1, 1'b0);
    en = 1'b0; load = 1'b1; load_val = 4'd7; limit = 4'd7;
    step(); load = 1'b0; sat = 1'b1; en = 1'b1;
    step(); chk_all("pre_rst", 4'd7, 1'b0, 1'b1, 1'b1);
    rst = 1'b1; load = 1'b1; load_val = 4'd3;
    step(); chk_all("mid_rst", 4'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; load = 1'b0; en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_updown_mod_n.md
Name: counter_updown_mod_n

Overview:
Parametrised synchronous up/down modulo-N counter for the division_devices family. It adds the following over the fixed binary ripple-enable counter:
- runtime modulus (terminal value)
- count direction
- parallel load
- wrap or saturate mode
- registered wrap strobe and a divide-by-2(N+1) square-wave output

It is used as a programmable frequency divider and event counter.

Parameters:
WIDTH, 8, counter width in bits (>= 2)
RESET_VALUE, 0, count value after reset (must be < 2**WIDTH)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous reset, active-high
en  input  1  count enable; one step per cycle while high
up_dn  input  1  direction: 1 = up, 0 = down
sat  input  1  mode: 0 = wrap, 1 = saturate
load  input  1  synchronous parallel load
load_val  input  WIDTH  value to load
limit  input  WIDTH  terminal count; legal range is 0..limit (modulus limit+1)
count  output  WIDTH  registered count
tc  output  1  combinational: count is at the terminal for the current direction
wrap  output  1  registered one-cycle pulse, high in the cycle count shows the wrapped value
div_out  output  1  registered; toggles on every wrap
sat_hit  output  1  registered sticky flag: a step was blocked by saturation

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Priority per rising edge: rst > load > en. With all three low, all registers hold and wrap = 0.
- Reset values: count = RESET_VALUE, wrap = 0, div_out = 0, sat_hit = 0. rst mid-operation overrides load/en in the same cycle; there is no partial update.
- Load:
  - count <= load_val, clamped to limit if load_val > limit.
  - sat_hit <= 0, wrap <= 0, div_out holds.
- Up step (en = 1, up_dn = 1):
  - count < limit: count + 1.
  - count >= limit, wrap mode: count <= 0, wrap <= 1, div_out toggles.
  - count >= limit, saturate mode: count <= limit, sat_hit <= 1, wrap <= 0.
- Down step (en = 1, up_dn = 0):
  - count > limit: count <= limit, no wrap. This covers limit lowered at runtime.
  - 0 < count <= limit: count - 1.
  - count == 0, wrap mode: count <= limit, wrap <= 1, div_out toggles.
  - count == 0, saturate mode: hold 0, sat_hit <= 1.
- Non-wrapping enabled steps drive wrap <= 0.
- tc:
  - up_dn = 1: tc = (count >= limit).
  - up_dn = 0: tc = (count == 0).
  - tc is not gated by en.
- limit = 0: count is pinned to 0. In wrap mode every enabled cycle is a wrap, so div_out = clk/2.
- Divider: with en held high, wrap mode and fixed limit L, wrap period = L+1 cycles and div_out period = 2(L+1) cycles at 50% duty. This holds in both directions.
- Arithmetic:
  - All comparisons are unsigned at WIDTH bits.
  - No carry beyond WIDTH. limit = 2**WIDTH-1 gives full binary wrap.
- Changes to up_dn, sat or limit take effect on the next enabled edge, with no pipeline delay.

Decomposition:
- Package counter_pkg:
  - typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e
  - typedef enum logic {MODE_WRAP = 1'b0, MODE_SAT = 1'b1} mode_e
- One combinational sub-module, counter_step:
  - Inputs: count, limit, dir, mode.
  - Outputs: next_count, wrap_evt, sat_evt, tc.
- The top holds only the registers, priority mux and div_out toggle.

Test Plan:
All scenarios use WIDTH = 4.
1. Reset then count up: rst high 2 cycles, release; limit = 9, up, wrap, en = 1 -> count 0,1,…,9,0. wrap is high exactly on each 9->0 cycle. div_out toggles every 10 cycles, period 20. tc = 1 while count = 9.
2. Down wrap: load_val = 2, limit = 5, down, wrap -> count 2,1,0,5,4. wrap pulses on the 0->5 cycle. tc = 1 while count = 0.
3. Saturate up: limit = 3, sat = 1, from 0 -> 0,1,2,3,3,3. sat_hit rises on the first blocked step and stays 1. A later load clears it to 0.
4. Load clamp and priority:
   - load_val = 12, limit = 9 -> count = 9.
   - load = 1 with en = 1, load_val = 4 -> count = 4; the step is ignored.
5. Runtime limit reduction: count = 8, then limit changed to 5.
   - Up wrap -> count 0 with wrap = 1.
   - Repeat with saturate -> count 5, sat_hit = 1.
   - Repeat with down -> count 5, no wrap.
6. Reset mid-operation: count = 7, div_out = 1, sat_hit = 1; assert rst together with load = 1 and en = 1 -> next edge count = RESET_VALUE (0), div_out = 0, sat_hit = 0, wrap = 0.
